mem_read_sequencer: RTL and testbench
=====================================

// Module: mem_read_sequencer
// PURPOSE
//  Read-side counterpart of the pixel/SV memory controller. Once the write phase ends
//  (decision_funct_en rises), sweeps test-vector memory and SV memory in lock-step, one
//  (x, sv) pixel pair per beat, and streams the pairs to the kernel/MAC stage over
//  valid/ready. Order: SV-major, pixel-minor. Absorbs the 1-cycle synchronous BRAM read
//  latency and downstream backpressure with a 2-entry skid FIFO.
// PARAMETERS
//  XLEN_PIXEL     8    pixel/SV element width (bits)
//  NUM_OF_PIXELS  784  pixels per vector
//  NUM_OF_SV      10   support vectors stored
//  (localparam) PIX_AW = $clog2(NUM_OF_PIXELS); SV_AW = $clog2(NUM_OF_PIXELS*NUM_OF_SV); IDX_W = $clog2(NUM_OF_SV)
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous, active-high reset
//  start        in   1           run trigger; connect to decision_funct_en (level); run launches on its rising edge
//  mem_re       out  1           read enable to both memories
//  x_raddr      out  PIX_AW      test-vector read address
//  sv_raddr     out  SV_AW       SV memory read address = sv_idx*NUM_OF_PIXELS + pix_idx
//  x_rdata      in   XLEN_PIXEL  test-vector data, valid 1 cycle after mem_re
//  sv_rdata     in   XLEN_PIXEL  SV data, valid 1 cycle after mem_re
//  out_valid    out  1           beat available
//  out_ready    in   1           downstream accepts beat
//  out_x        out  XLEN_PIXEL  test pixel
//  out_sv       out  XLEN_PIXEL  SV pixel
//  out_sv_idx   out  IDX_W       SV index of beat
//  out_last_pix out  1           last pixel of current SV
//  out_last_sv  out  1           last pixel of last SV (final beat)
//  busy         out  1           high from launch until done
//  done         out  1           1-cycle pulse after final beat accepted
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters, FIFO, in-flight flag and start_d cleared.
//  FSM: IDLE -(start & ~start_d)-> RUN -(last addr issued)-> DRAIN -(FIFO empty & no read in flight)-> DONE -> IDLE.
//  DONE lasts exactly one cycle: done=1 there; busy=1 in RUN/DRAIN only.
//  Issue rule (RUN): mem_re=1 iff fifo_count + inflight < 2, evaluated with same-cycle pop
//   (fifo_count counts entries after pop). Counters pix_idx/sv_idx advance on every issue.
//  Wrap: pix_idx==NUM_OF_PIXELS-1 -> 0 and sv_idx++; issue at (NUM_OF_SV-1, NUM_OF_PIXELS-1) is last -> DRAIN.
//  Read data: inflight flag set on mem_re, cleared next cycle; returning data plus
//   registered sv_idx/last flags pushed into FIFO on that cycle. Credit rule guarantees no overflow.
//  Output: out_valid = FIFO non-empty; outputs = FIFO head; pop on out_valid & out_ready.
//   Simultaneous push and pop permitted at any fill level. Outputs stable while valid & ~ready.
//  Throughput: 1 beat/cycle with out_ready held high; first beat out_valid 2 cycles after start edge.
//  Total beats = NUM_OF_PIXELS*NUM_OF_SV, no gaps under constant ready, no duplicates/drops.
//  start edge while busy: ignored. start held high after done: no relaunch until it falls and rises.
//  rst mid-run: aborts immediately, FIFO flushed, in-flight data discarded, no done pulse.
//  sv_raddr computed incrementally (running base + pix_idx, base += NUM_OF_PIXELS on wrap); no multiplier.
// STRUCTURE
//  Shared package svm_pkg: XLEN_PIXEL, NUM_OF_PIXELS, NUM_OF_SV, derived address widths,
//   FSM state encoding (IDLE/RUN/DRAIN/DONE).
//  One sub-module: skid_fifo2 (2-entry FIFO, width 2*XLEN_PIXEL+IDX_W+2, push/pop/count).
// TESTING (bench params NUM_OF_PIXELS=4, NUM_OF_SV=2, memories as 1-cycle sync BRAM models,
//  x[i]=i+1, sv[a]=a+16)
//  1 start rises, out_ready=1 -> 8 consecutive beats: (x,sv)=(1,16),(2,17),(3,18),(4,19),(1,20)..(4,23);
//    out_last_pix on beats 4,8; out_last_sv on beat 8 only; done pulse 1 cycle after beat 8; busy low after.
//  2 out_ready toggles 1,0,0,1 repeatedly -> same 8-beat sequence in order, outputs stable during stalls,
//    mem_re never issued with fifo_count+inflight==2.
//  3 out_ready=0 from launch for 10 cycles -> exactly 2 reads issued, FIFO full, then release -> all 8 beats.
//  4 rst asserted at beat 3 of run -> next cycle out_valid=0, busy=0, no done; new start edge restarts at (1,16).
//  5 start held high after done; second pulse while busy -> no relaunch / ignored; low->high edge -> full rerun.
//  6 Default params, ready random 70% -> scoreboard 7840 beats, sv_raddr max 7839, exactly one done.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared SVM constants: default pixel/SV geometry, derived address widths and
// the read-sequencer FSM encoding.
package svm_pkg;
  localparam int DEF_XLEN_PIXEL    = 8;
  localparam int DEF_NUM_OF_PIXELS = 784;
  localparam int DEF_NUM_OF_SV     = 10;
  localparam int DEF_PIX_AW        = $clog2(DEF_NUM_OF_PIXELS);
  localparam int DEF_SV_AW         = $clog2(DEF_NUM_OF_PIXELS * DEF_NUM_OF_SV);
  localparam int DEF_IDX_W         = $clog2(DEF_NUM_OF_SV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;
endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with registered head; push and pop may coincide at any fill
// level (at full, the pop frees the slot the push writes).
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/mem_read_sequencer.sv
// Sweeps test-vector and SV memories in lock-step (SV-major, pixel-minor) and
// streams (x, sv) pairs downstream; a 2-entry FIFO absorbs BRAM latency.
module mem_read_sequencer #(
  parameter int XLEN_PIXEL    = svm_pkg::DEF_XLEN_PIXEL,
  parameter int NUM_OF_PIXELS = svm_pkg::DEF_NUM_OF_PIXELS,
  parameter int NUM_OF_SV     = svm_pkg::DEF_NUM_OF_SV
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  output logic                                       mem_re,
  output logic [$clog2(NUM_OF_PIXELS)-1:0]           x_raddr,
  output logic [$clog2(NUM_OF_PIXELS*NUM_OF_SV)-1:0] sv_raddr,
  input  logic [XLEN_PIXEL-1:0]                      x_rdata,
  input  logic [XLEN_PIXEL-1:0]                      sv_rdata,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [XLEN_PIXEL-1:0]                      out_x,
  output logic [XLEN_PIXEL-1:0]                      out_sv,
  output logic [$clog2(NUM_OF_SV)-1:0]               out_sv_idx,
  output logic                                       out_last_pix,
  output logic                                       out_last_sv,
  output logic                                       busy,
  output logic                                       done,
  output svm_pkg::seq_state_e                        fsm_state
);
  import svm_pkg::*;

  localparam int PIX_AW = $clog2(NUM_OF_PIXELS);
  localparam int SV_AW  = $clog2(NUM_OF_PIXELS * NUM_OF_SV);
  localparam int IDX_W  = $clog2(NUM_OF_SV);
  localparam int FW     = 2 * XLEN_PIXEL + IDX_W + 2;
  localparam logic [PIX_AW-1:0] PIX_LAST = PIX_AW'(NUM_OF_PIXELS - 1);
  localparam logic [IDX_W-1:0]  SV_LAST  = IDX_W'(NUM_OF_SV - 1);
  localparam logic [SV_AW-1:0]  PIX_STEP = SV_AW'(NUM_OF_PIXELS);

  // Handshake: a beat transfers on every cycle where out_valid & out_ready are
  // both high; out_valid never drops and head never changes until that happens.

  seq_state_e        state, state_nxt;
  logic              start_d;
  logic              launch;
  logic              inflight;
  logic [PIX_AW-1:0] pix_idx;
  logic [IDX_W-1:0]  sv_idx;
  logic [SV_AW-1:0]  sv_base;
  logic              at_last;
  logic [IDX_W-1:0]  meta_idx;
  logic              meta_last_pix;
  logic              meta_last_sv;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [1:0]        count_after;
  logic [FW-1:0]     push_data;
  logic [FW-1:0]     head;

  assign launch      = (state == ST_IDLE) && start && !start_d;
  assign pop         = out_valid && out_ready;
  assign count_after = fifo_count - {1'b0, pop};
  assign at_last     = (pix_idx == PIX_LAST) && (sv_idx == SV_LAST);

  always_comb begin
    state_nxt = state;
    mem_re    = 1'b0;
    case (state)
      ST_IDLE:  if (launch) state_nxt = ST_RUN;
      ST_RUN: begin
        // Credit: entries left after this cycle's pop plus the read in flight.
        mem_re = (count_after + {1'b0, inflight}) < 2'd2;
        if (mem_re && at_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (count_after == 2'd0 && !inflight) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      start_d       <= 1'b0;
      inflight      <= 1'b0;
      pix_idx       <= '0;
      sv_idx        <= '0;
      sv_base       <= '0;
      meta_idx      <= '0;
      meta_last_pix <= 1'b0;
      meta_last_sv  <= 1'b0;
    end else begin
      state    <= state_nxt;
      start_d  <= start;
      inflight <= mem_re;
      if (launch) begin
        pix_idx <= '0;
        sv_idx  <= '0;
        sv_base <= '0;
      end else if (mem_re) begin
        meta_idx      <= sv_idx;
        meta_last_pix <= (pix_idx == PIX_LAST);
        meta_last_sv  <= at_last;
        if (at_last) begin
          pix_idx <= '0;
          sv_idx  <= '0;
          sv_base <= '0;
        end else if (pix_idx == PIX_LAST) begin
          pix_idx <= '0;
          sv_idx  <= sv_idx + IDX_W'(1);
          sv_base <= sv_base + PIX_STEP;
        end else begin
          pix_idx <= pix_idx + PIX_AW'(1);
        end
      end
    end
  end

  assign x_raddr   = pix_idx;
  assign sv_raddr  = sv_base + SV_AW'(pix_idx);
  assign push_data = {x_rdata, sv_rdata, meta_idx, meta_last_pix, meta_last_sv};

  skid_fifo2 #(.W(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign out_valid    = (fifo_count != 2'd0);
  assign out_x        = head[FW-1 -: XLEN_PIXEL];
  assign out_sv       = head[FW-1-XLEN_PIXEL -: XLEN_PIXEL];
  assign out_sv_idx   = head[2 +: IDX_W];
  assign out_last_pix = head[1];
  assign out_last_sv  = head[0];
  assign busy         = (state == ST_RUN) || (state == ST_DRAIN);
  assign done         = (state == ST_DONE);
  assign fsm_state    = state;
endmodule

// File: tb/tb_mem_read_sequencer.sv
// Bench for mem_read_sequencer: small instance (4 pixels x 2 SVs) for directed
// scenarios, default-size instance for a long random-backpressure sweep.
module tb_mem_read_sequencer;
  localparam int NPS = 4;
  localparam int NSS = 2;
  localparam int NPL = 784;
  localparam int NSL = 10;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  // small instance signals
  logic       start_s, ready_s, mem_re_s, out_valid_s, out_last_pix_s, out_last_sv_s, busy_s, done_s;
  logic [1:0] x_raddr_s;
  logic [2:0] sv_raddr_s;
  logic [7:0] x_rdata_s, sv_rdata_s, out_x_s, out_sv_s;
  logic [0:0] out_sv_idx_s;
  svm_pkg::seq_state_e fsm_state_s;

  // default-size instance signals
  logic        start_l, ready_l, mem_re_l, out_valid_l, out_last_pix_l, out_last_sv_l, busy_l, done_l;
  logic [9:0]  x_raddr_l;
  logic [12:0] sv_raddr_l;
  logic [7:0]  x_rdata_l, sv_rdata_l, out_x_l, out_sv_l;
  logic [3:0]  out_sv_idx_l;
  svm_pkg::seq_state_e fsm_state_l;

  mem_read_sequencer #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(NPS), .NUM_OF_SV(NSS)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .mem_re(mem_re_s), .x_raddr(x_raddr_s),
    .sv_raddr(sv_raddr_s), .x_rdata(x_rdata_s), .sv_rdata(sv_rdata_s), .out_valid(out_valid_s),
    .out_ready(ready_s), .out_x(out_x_s), .out_sv(out_sv_s), .out_sv_idx(out_sv_idx_s),
    .out_last_pix(out_last_pix_s), .out_last_sv(out_last_sv_s), .busy(busy_s), .done(done_s),
    .fsm_state(fsm_state_s)
  );

  mem_read_sequencer dut_l (
    .clk(clk), .rst(rst), .start(start_l), .mem_re(mem_re_l), .x_raddr(x_raddr_l),
    .sv_raddr(sv_raddr_l), .x_rdata(x_rdata_l), .sv_rdata(sv_rdata_l), .out_valid(out_valid_l),
    .out_ready(ready_l), .out_x(out_x_l), .out_sv(out_sv_l), .out_sv_idx(out_sv_idx_l),
    .out_last_pix(out_last_pix_l), .out_last_sv(out_last_sv_l), .busy(busy_l), .done(done_l),
    .fsm_state(fsm_state_l)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle synchronous BRAM models: x[i] = i+1, sv[a] = a+16
  always @(posedge clk) begin
    if (mem_re_s) begin
      x_rdata_s  <= 8'({6'b0, x_raddr_s} + 8'd1);
      sv_rdata_s <= 8'({5'b0, sv_raddr_s} + 8'd16);
    end
    if (mem_re_l) begin
      x_rdata_l  <= 8'(x_raddr_l + 10'd1);
      sv_rdata_l <= 8'(sv_raddr_l + 13'd16);
    end
  end

  // scoreboard storage
  logic [21:0] exp_q[$];
  logic [21:0] obs_q[$];
  int first_valid_c, last_beat_c, done_c, done_cnt, stall_viol, credit_viol, reads_by10, busy_after;

  function automatic logic [21:0] pack(input int x, input int sv, input int idx, input bit lp, input bit ls);
    logic [7:0] xb, sb;
    logic [3:0] ib;
    xb = x[7:0];
    sb = sv[7:0];
    ib = idx[3:0];
    return {xb, sb, ib, lp, ls};
  endfunction

  // Expected stream from the sweep definition: beat k is SV k/np, pixel k%np.
  task automatic build_exp(input int np, input int ns);
    exp_q.delete();
    for (int k = 0; k < np * ns; k++)
      exp_q.push_back(pack((k % np) + 1, k + 16, k / np, (k % np) == np - 1, k == np * ns - 1));
  endtask

  // Driver/monitor for the small instance; mode selects the out_ready pattern.
  task automatic run_small(input int mode, input bit pulse, input int max_cyc);
    int outstanding = 0;
    bit prev_stall = 0;
    logic [21:0] prev_beat = '0;
    logic [21:0] beat;
    bit pop;
    obs_q.delete();
    first_valid_c = -1; last_beat_c = -1; done_c = -1; done_cnt = 0;
    stall_viol = 0; credit_viol = 0; reads_by10 = 0; busy_after = 0;
    @(posedge clk); #1 start_s = 1'b0;
    @(posedge clk); #1 start_s = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      case (mode)
        0:       ready_s = 1'b1;
        1:       ready_s = (c % 4 == 0) || (c % 4 == 3);
        2:       ready_s = (c >= 10);
        default: ready_s = 1'($urandom_range(0, 1));
      endcase
      if (pulse && c == 4) start_s = 1'b0;
      if (pulse && c == 5) start_s = 1'b1;
      @(negedge clk);
      beat = {out_x_s, out_sv_s, 3'b000, out_sv_idx_s, out_last_pix_s, out_last_sv_s};
      pop  = out_valid_s && ready_s;
      if (prev_stall && (!out_valid_s || beat !== prev_beat)) stall_viol++;
      if (mem_re_s && (outstanding - int'(pop)) >= 2) credit_viol++;
      if (mem_re_s && c < 10) reads_by10++;
      if (out_valid_s && first_valid_c < 0) first_valid_c = c;
      if (pop) begin
        obs_q.push_back(beat);
        last_beat_c = c;
      end
      if (done_s) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c > done_c && busy_s) busy_after++;
      outstanding += int'(mem_re_s) - int'(pop);
      prev_stall = out_valid_s && !ready_s;
      prev_beat  = beat;
      if (done_c >= 0 && c >= done_c + 15) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_s = 1'b0; ready_s = 1'b0; start_l = 1'b0; ready_l = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({mem_re_s, out_valid_s, busy_s, done_s, out_last_pix_s, out_last_sv_s} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl got %b want 000000", {mem_re_s, out_valid_s, busy_s, done_s, out_last_pix_s, out_last_sv_s});
    end
    n_vec++;
    if ({x_raddr_s, sv_raddr_s, out_x_s, out_sv_s, out_sv_idx_s} !== 22'b0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {x_raddr_s, sv_raddr_s, out_x_s, out_sv_s, out_sv_idx_s});
    end
    n_vec++;
    if (fsm_state_s !== svm_pkg::ST_IDLE) begin
      n_err++; $display("FAIL reset_state got %0d want %0d", fsm_state_s, svm_pkg::ST_IDLE);
    end
    n_vec++;
    if ({busy_l, out_valid_l, mem_re_l, done_l} !== 4'b0) begin
      n_err++; $display("FAIL reset_large got %b want 0000", {busy_l, out_valid_l, mem_re_l, done_l});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    build_exp(NPS, NSS);
    run_small(0, 1'b0, 60);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL basic_beats got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (first_valid_c != 2) begin
      n_err++; $display("FAIL basic_latency got %0d want 2", first_valid_c);
    end
    n_vec++;
    if (last_beat_c - first_valid_c != 7) begin
      n_err++; $display("FAIL basic_gapless got span %0d want 7", last_beat_c - first_valid_c);
    end
    n_vec++;
    if (done_c != last_beat_c + 1 || done_cnt != 1) begin
      n_err++; $display("FAIL basic_done got cycle %0d count %0d want cycle %0d count 1", done_c, done_cnt, last_beat_c + 1);
    end
    n_vec++;
    if (busy_after != 0) begin
      n_err++; $display("FAIL basic_busy_after got %0d want 0", busy_after);
    end
  endtask

  task automatic test_backpressure;
    build_exp(NPS, NSS);
    run_small(1, 1'b0, 80);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL bp_beats got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (stall_viol != 0) begin
      n_err++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_viol);
    end
    n_vec++;
    if (credit_viol != 0) begin
      n_err++; $display("FAIL bp_credit got %0d over-issues want 0", credit_viol);
    end
    n_vec++;
    if (done_cnt != 1) begin
      n_err++; $display("FAIL bp_done got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_full_stall;
    build_exp(NPS, NSS);
    run_small(2, 1'b0, 80);
    n_vec++;
    if (reads_by10 != 2) begin
      n_err++; $display("FAIL stall_reads got %0d want 2", reads_by10);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL stall_beats got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL stall_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (stall_viol != 0 || credit_viol != 0 || done_cnt != 1) begin
      n_err++; $display("FAIL stall_misc got stall %0d credit %0d done %0d want 0 0 1", stall_viol, credit_viol, done_cnt);
    end
  endtask

  task automatic test_reset_midrun;
    int beats = 0;
    int dones = 0;
    @(posedge clk); #1 start_s = 1'b0; ready_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b1;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      @(negedge clk);
      if (out_valid_s) beats++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({out_valid_s, busy_s, done_s, mem_re_s} !== 4'b0) begin
      n_err++; $display("FAIL midrst_abort got valid/busy/done/re %b want 0000", {out_valid_s, busy_s, done_s, mem_re_s});
    end
    @(negedge clk);
    rst = 1'b0; start_s = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_s || busy_s) dones++;
    end
    n_vec++;
    if (dones != 0) begin
      n_err++; $display("FAIL midrst_no_done got %0d active cycles want 0", dones);
    end
    build_exp(NPS, NSS);
    run_small(0, 1'b0, 60);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL midrst_beats got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL midrst_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_rules;
    int busy_cnt = 0;
    // start is still high from the previous run
    repeat (20) begin
      @(negedge clk);
      if (busy_s) busy_cnt++;
    end
    n_vec++;
    if (busy_cnt != 0) begin
      n_err++; $display("FAIL hold_relaunch got %0d busy cycles want 0", busy_cnt);
    end
    build_exp(NPS, NSS);
    run_small(0, 1'b1, 60);
    n_vec++;
    if (obs_q.size() != exp_q.size() || done_cnt != 1) begin
      n_err++; $display("FAIL pulse_busy got beats %0d done %0d want %0d 1", obs_q.size(), done_cnt, exp_q.size());
    end
    n_vec++;
    if (busy_after != 0) begin
      n_err++; $display("FAIL pulse_relaunch got %0d busy cycles after done want 0", busy_after);
    end
    run_small(3, 1'b0, 80);
    n_vec++;
    if (obs_q.size() != exp_q.size() || done_cnt != 1) begin
      n_err++; $display("FAIL rerun got beats %0d done %0d want %0d 1", obs_q.size(), done_cnt, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL rerun_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_default_random;
    int k = 0;
    int dones = 0;
    int max_addr = -1;
    int post = 0;
    logic [21:0] beat;
    logic [21:0] want;
    build_exp(NPL, NSL);
    @(posedge clk); #1 start_l = 1'b1;
    for (int c = 0; c < 20000 && post < 5; c++) begin
      @(posedge clk); #1;
      ready_l = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      if (mem_re_l && int'(sv_raddr_l) > max_addr) max_addr = int'(sv_raddr_l);
      if (out_valid_l && ready_l) begin
        beat = {out_x_l, out_sv_l, out_sv_idx_l, out_last_pix_l, out_last_sv_l};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3fffff;
        n_vec++;
        if (beat !== want) begin
          n_err++; $display("FAIL rand_beat%0d got %h want %h", k, beat, want);
        end
        k++;
      end
      if (done_l) dones++;
      if (dones > 0) post++;
    end
    n_vec++;
    if (k != NPL * NSL) begin
      n_err++; $display("FAIL rand_total got %0d want %0d", k, NPL * NSL);
    end
    n_vec++;
    if (max_addr != NPL * NSL - 1) begin
      n_err++; $display("FAIL rand_max_addr got %0d want %0d", max_addr, NPL * NSL - 1);
    end
    n_vec++;
    if (dones != 1) begin
      n_err++; $display("FAIL rand_done got %0d want 1", dones);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_rules();
    test_backpressure();
    test_full_stall();
    test_reset_midrun();
    test_default_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
